// File: rtl/banked_regfile_if.sv
// Register-file port bundle: read ports, ALU/load write ports, PC, PSR and exception controls.
// master drives requests and consumes read data; slave is the register file.
interface banked_regfile_if #(
   parameter int DATA_W = 32,
   parameter int NRD    = 3
);
   logic [NRD*4-1:0]      rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;

   logic                  wr_en;
   logic [3:0]            wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  ld_en;
   logic [3:0]            ld_addr;
   logic [DATA_W-1:0]     ld_data;

   logic                  pc_load;
   logic [DATA_W-1:0]     pc_wdata;
   logic [DATA_W-1:0]     pc_rdata;

   logic                  flags_load;
   logic [3:0]            flags_wdata;
   logic                  psr_load;
   logic                  psr_w_sel;
   logic [31:0]           psr_wdata;
   logic                  psr_r_sel;
   logic [DATA_W-1:0]     psr_rdata;

   logic                  exc_req;
   logic [4:0]            exc_mode;
   logic [DATA_W-1:0]     exc_ret_addr;
   logic                  spsr_restore;
   logic [4:0]            cur_mode;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data,
             pc_load, pc_wdata, flags_load, flags_wdata, psr_load, psr_w_sel,
             psr_wdata, psr_r_sel, exc_req, exc_mode, exc_ret_addr, spsr_restore,
      input  rd_data, pc_rdata, psr_rdata, cur_mode
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data,
             pc_load, pc_wdata, flags_load, flags_wdata, psr_load, psr_w_sel,
             psr_wdata, psr_r_sel, exc_req, exc_mode, exc_ret_addr, spsr_restore,
      output rd_data, pc_rdata, psr_rdata, cur_mode
   );
endinterface

// File: rtl/banked_regfile.sv
// Mode-banked ARM register file with PC, CPSR, per-mode SPSRs and one-edge exception entry/return.
// Reads combinational, updates visible after posedge, never stalls; RF_BYPASS_EN forwards same-cycle writes to read ports.
module banked_regfile #(
   parameter int DATA_W = 32,
   parameter int NRD    = 3
) (
   input logic            sysclk,
   input logic            reset,
   banked_regfile_if.slave rf
);

   typedef enum logic [2:0] {B_USR, B_FIQ, B_IRQ, B_SVC, B_ABT, B_UND} bank_e;

   // Physical map: 0-14 user R0-R14, 15-21 FIQ R8-R14, then R13/R14 pairs for IRQ/SVC/ABT/UND, 30 = PC.
   localparam int         NPHYS  = 31;
   localparam logic [4:0] PC_IDX = 5'd30;

   function automatic bank_e mode_bank(input logic [4:0] m);
      case (m)
         5'b10001: return B_FIQ;
         5'b10010: return B_IRQ;
         5'b10011: return B_SVC;
         5'b10111: return B_ABT;
         5'b11011: return B_UND;
         default:  return B_USR;
      endcase
   endfunction

   function automatic logic [4:0] phys_idx(input bank_e b, input logic [3:0] a);
      logic [4:0] off;
      off = 5'd0;
      if (a == 4'd15) return PC_IDX;
      case (b)
         B_FIQ:   if (a >= 4'd8)  off = 5'd7;
         B_IRQ:   if (a >= 4'd13) off = 5'd9;
         B_SVC:   if (a >= 4'd13) off = 5'd11;
         B_ABT:   if (a >= 4'd13) off = 5'd13;
         B_UND:   if (a >= 4'd13) off = 5'd15;
         default: off = 5'd0;
      endcase
      return 5'(a) + off;
   endfunction

   function automatic logic [2:0] spsr_idx(input bank_e b);
      return 3'(b) - 3'd1;
   endfunction

   logic [DATA_W-1:0] regs_q [NPHYS];
   logic [DATA_W-1:0] regs_d [NPHYS];
   logic [DATA_W-1:0] rd_src [NPHYS];
   logic [31:0]       spsr_q [5];
   logic [31:0]       spsr_d [5];
   logic [31:0]       cpsr_q, cpsr_d;
   logic [31:0]       spsr_cur;
   bank_e             cur_bank, exc_bank;
   logic              cur_priv, exc_take;
   logic [4:0]        wr_idx, ld_idx, exc_lr_idx;

   assign cur_bank   = mode_bank(cpsr_q[4:0]);
   assign exc_bank   = mode_bank(rf.exc_mode);
   assign cur_priv   = (cur_bank != B_USR);
   assign exc_take   = rf.exc_req && (exc_bank != B_USR);
   assign wr_idx     = phys_idx(cur_bank, rf.wr_addr);
   assign ld_idx     = phys_idx(cur_bank, rf.ld_addr);
   assign exc_lr_idx = phys_idx(exc_bank, 4'd14);
   assign spsr_cur   = cur_priv ? spsr_q[spsr_idx(cur_bank)] : 32'd0;

   // Later assignments win: pc_load < wr < ld < exception link register.
   always_comb begin
      regs_d = regs_q;
      if (rf.pc_load) regs_d[PC_IDX] = rf.pc_wdata;
      if (rf.wr_en)   regs_d[wr_idx] = rf.wr_data;
      if (rf.ld_en)   regs_d[ld_idx] = rf.ld_data;
      if (exc_take)   regs_d[exc_lr_idx] = rf.exc_ret_addr;
   end

   always_comb begin
      cpsr_d = cpsr_q;
      if (exc_take) begin
         cpsr_d[4:0] = rf.exc_mode;
         cpsr_d[7]   = 1'b1;
         if (exc_bank == B_FIQ) cpsr_d[6] = 1'b1;
      end else if (rf.spsr_restore && cur_priv) begin
         cpsr_d = spsr_cur;
      end else if (rf.psr_load && !rf.psr_w_sel) begin
         cpsr_d = rf.psr_wdata;
      end else if (rf.flags_load) begin
         cpsr_d[31:28] = rf.flags_wdata;
      end
   end

   always_comb begin
      spsr_d = spsr_q;
      if (rf.psr_load && rf.psr_w_sel && cur_priv) spsr_d[spsr_idx(cur_bank)] = rf.psr_wdata;
      if (exc_take) spsr_d[spsr_idx(exc_bank)] = cpsr_q;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
         for (int i = 0; i < 5; i++)     spsr_q[i] <= '0;
         cpsr_q <= 32'h0000_00D3;
      end else begin
         regs_q <= regs_d;
         spsr_q <= spsr_d;
         cpsr_q <= cpsr_d;
      end
   end

`ifdef RF_BYPASS_EN
   always_comb rd_src = regs_d;
`else
   always_comb rd_src = regs_q;
`endif

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign rf.rd_data[i*DATA_W +: DATA_W] = rd_src[phys_idx(cur_bank, rf.rd_addr[i*4 +: 4])];
   end

   assign rf.pc_rdata  = regs_q[PC_IDX];
   assign rf.psr_rdata = DATA_W'(rf.psr_r_sel ? spsr_cur : cpsr_q);
   assign rf.cur_mode  = cpsr_q[4:0];

endmodule

// File: tb/tb_banked_regfile.sv
// Directed self-checking bench for banked_regfile: reset, banking, collisions, exceptions, priority, bypass.
module tb_banked_regfile;
   localparam int DW  = 32;
   localparam int NRD = 3;

   logic sysclk = 1'b0;
   logic reset  = 1'b1;
   int   vecs   = 0;
   int   errs   = 0;

   banked_regfile_if #(.DATA_W(DW), .NRD(NRD)) rf_if ();

   banked_regfile #(.DATA_W(DW), .NRD(NRD)) dut (
      .sysclk (sysclk),
      .reset  (reset),
      .rf     (rf_if.slave)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic idle();
      rf_if.wr_en = 0;        rf_if.wr_addr = 0;     rf_if.wr_data = 0;
      rf_if.ld_en = 0;        rf_if.ld_addr = 0;     rf_if.ld_data = 0;
      rf_if.pc_load = 0;      rf_if.pc_wdata = 0;
      rf_if.flags_load = 0;   rf_if.flags_wdata = 0;
      rf_if.psr_load = 0;     rf_if.psr_w_sel = 0;   rf_if.psr_wdata = 0;
      rf_if.psr_r_sel = 0;
      rf_if.exc_req = 0;      rf_if.exc_mode = 0;    rf_if.exc_ret_addr = 0;
      rf_if.spsr_restore = 0;
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic [3:0] a);
      rf_if.rd_addr[p*4 +: 4] = a;
      #1;
   endtask

   function automatic logic [DW-1:0] rd(input int p);
      return rf_if.rd_data[p*DW +: DW];
   endfunction

   task automatic do_wr(input logic [3:0] a, input logic [DW-1:0] d);
      rf_if.wr_en = 1; rf_if.wr_addr = a; rf_if.wr_data = d;
      tick();
      idle();
   endtask

   task automatic do_cpsr(input logic [31:0] v);
      rf_if.psr_load = 1; rf_if.psr_w_sel = 0; rf_if.psr_wdata = v;
      tick();
      idle();
   endtask

   task automatic test_reset();
      logic [DW-1:0] v;
      idle();
      rf_if.rd_addr = '0;
      reset = 1;
      rf_if.wr_en = 1; rf_if.wr_addr = 4'd2; rf_if.wr_data = 32'h77;
      repeat (2) @(posedge sysclk);
      #1;
      reset = 0;
      idle();
      #1;
      vecs++; if (rf_if.psr_rdata !== 32'hD3) begin errs++; $display("FAIL reset_psr got %h exp %h", rf_if.psr_rdata, 32'hD3); end
      vecs++; if (rf_if.cur_mode !== 5'b10011) begin errs++; $display("FAIL reset_mode got %b exp 10011", rf_if.cur_mode); end
      vecs++; if (rf_if.pc_rdata !== 0) begin errs++; $display("FAIL reset_pc got %h exp 0", rf_if.pc_rdata); end
      set_rd(0, 4'd2); set_rd(1, 4'd13); set_rd(2, 4'd15);
      vecs++; if (rd(0) !== 0 || rd(1) !== 0 || rd(2) !== 0) begin errs++; $display("FAIL reset_reads got %h %h %h exp 0", rd(0), rd(1), rd(2)); end
      // Dirty state, then an asynchronous reset pulse between edges.
      rf_if.flags_load = 1; rf_if.flags_wdata = 4'hF;
      do_wr(4'd1, 32'h5);
      set_rd(0, 4'd1);
      vecs++; if (rd(0) !== 32'h5) begin errs++; $display("FAIL pre_async_r1 got %h exp 5", rd(0)); end
      vecs++; if (rf_if.psr_rdata !== 32'hF00000D3) begin errs++; $display("FAIL pre_async_psr got %h exp F00000D3", rf_if.psr_rdata); end
      reset = 1;
      #1;
      v = rd(0);
      vecs++; if (v !== 0) begin errs++; $display("FAIL async_r1 got %h exp 0", v); end
      vecs++; if (rf_if.psr_rdata !== 32'hD3) begin errs++; $display("FAIL async_psr got %h exp D3", rf_if.psr_rdata); end
      #1;
      reset = 0;
   endtask

   task automatic test_banking();
      do_cpsr(32'h10);
      vecs++; if (rf_if.cur_mode !== 5'b10000) begin errs++; $display("FAIL bank_usr_mode got %b exp 10000", rf_if.cur_mode); end
      do_wr(4'd13, 32'h11);
      do_cpsr(32'h12);
      do_wr(4'd13, 32'h22);
      set_rd(1, 4'd13);
      vecs++; if (rd(1) !== 32'h22) begin errs++; $display("FAIL bank_irq_r13 got %h exp 22", rd(1)); end
      do_cpsr(32'h10);
      vecs++; if (rd(1) !== 32'h11) begin errs++; $display("FAIL bank_usr_r13 got %h exp 11", rd(1)); end
      // Write mapped through the mode in effect before the edge that changes it.
      rf_if.psr_load = 1; rf_if.psr_wdata = 32'h12;
      rf_if.wr_en = 1; rf_if.wr_addr = 4'd13; rf_if.wr_data = 32'h44;
      tick(); idle(); #1;
      vecs++; if (rd(1) !== 32'h22) begin errs++; $display("FAIL bank_switch_irq_r13 got %h exp 22", rd(1)); end
      do_cpsr(32'h00);
      vecs++; if (rf_if.cur_mode !== 5'b00000) begin errs++; $display("FAIL bank_raw_mode got %b exp 00000", rf_if.cur_mode); end
      vecs++; if (rd(1) !== 32'h44) begin errs++; $display("FAIL bank_invalid_as_usr got %h exp 44", rd(1)); end
      do_cpsr(32'h11);
      do_wr(4'd8, 32'h33);
      set_rd(2, 4'd8);
      vecs++; if (rd(2) !== 32'h33) begin errs++; $display("FAIL bank_fiq_r8 got %h exp 33", rd(2)); end
      do_cpsr(32'h10);
      vecs++; if (rd(2) !== 0) begin errs++; $display("FAIL bank_usr_r8 got %h exp 0", rd(2)); end
   endtask

   task automatic test_collision();
      rf_if.wr_en = 1; rf_if.wr_addr = 4'd3; rf_if.wr_data = 32'hAAAA;
      rf_if.ld_en = 1; rf_if.ld_addr = 4'd3; rf_if.ld_data = 32'h5555;
      tick(); idle();
      set_rd(0, 4'd3);
      vecs++; if (rd(0) !== 32'h5555) begin errs++; $display("FAIL coll_r3 got %h exp 5555", rd(0)); end
      rf_if.wr_en = 1; rf_if.wr_addr = 4'd15; rf_if.wr_data = 32'h100;
      rf_if.pc_load = 1; rf_if.pc_wdata = 32'h8;
      tick(); idle(); #1;
      vecs++; if (rf_if.pc_rdata !== 32'h100) begin errs++; $display("FAIL coll_pc got %h exp 100", rf_if.pc_rdata); end
      set_rd(0, 4'd15);
      vecs++; if (rd(0) !== 32'h100) begin errs++; $display("FAIL coll_r15 got %h exp 100", rd(0)); end
      rf_if.pc_load = 1; rf_if.pc_wdata = 32'h8;
      tick(); idle(); #1;
      vecs++; if (rf_if.pc_rdata !== 32'h8) begin errs++; $display("FAIL pc_load got %h exp 8", rf_if.pc_rdata); end
   endtask

   task automatic test_exception();
      do_cpsr(32'hF0000010);
      rf_if.exc_req = 1; rf_if.exc_mode = 5'b10011; rf_if.exc_ret_addr = 32'h40;
      tick(); idle();
      set_rd(1, 4'd14);
      vecs++; if (rf_if.psr_rdata !== 32'hF0000093) begin errs++; $display("FAIL exc_cpsr got %h exp F0000093", rf_if.psr_rdata); end
      vecs++; if (rd(1) !== 32'h40) begin errs++; $display("FAIL exc_r14_svc got %h exp 40", rd(1)); end
      rf_if.psr_r_sel = 1; #1;
      vecs++; if (rf_if.psr_rdata !== 32'hF0000010) begin errs++; $display("FAIL exc_spsr_svc got %h exp F0000010", rf_if.psr_rdata); end
      rf_if.spsr_restore = 1;
      tick(); idle(); #1;
      vecs++; if (rf_if.psr_rdata !== 32'hF0000010) begin errs++; $display("FAIL exc_restore got %h exp F0000010", rf_if.psr_rdata); end
      vecs++; if (rd(1) !== 0) begin errs++; $display("FAIL exc_usr_r14 got %h exp 0", rd(1)); end
      rf_if.exc_req = 1; rf_if.exc_mode = 5'b00000; rf_if.exc_ret_addr = 32'h77;
      tick(); idle(); #1;
      vecs++; if (rf_if.psr_rdata !== 32'hF0000010 || rd(1) !== 0) begin errs++; $display("FAIL exc_bad_mode got %h/%h exp F0000010/0", rf_if.psr_rdata, rd(1)); end
      rf_if.spsr_restore = 1;
      tick(); idle(); #1;
      vecs++; if (rf_if.psr_rdata !== 32'hF0000010) begin errs++; $display("FAIL restore_in_usr got %h exp F0000010", rf_if.psr_rdata); end
      rf_if.exc_req = 1; rf_if.exc_mode = 5'b10001; rf_if.exc_ret_addr = 32'h1C;
      tick(); idle(); #1;
      vecs++; if (rf_if.psr_rdata !== 32'hF00000D1 || rd(1) !== 32'h1C) begin errs++; $display("FAIL exc_fiq got %h/%h exp F00000D1/1C", rf_if.psr_rdata, rd(1)); end
      rf_if.spsr_restore = 1;
      tick(); idle();
      do_cpsr(32'h13);
      rf_if.exc_req = 1; rf_if.exc_mode = 5'b10011; rf_if.exc_ret_addr = 32'h50;
      rf_if.wr_en = 1; rf_if.wr_addr = 4'd14; rf_if.wr_data = 32'h99;
      tick(); idle(); #1;
      vecs++; if (rd(1) !== 32'h50) begin errs++; $display("FAIL exc_lr_override got %h exp 50", rd(1)); end
   endtask

   task automatic test_priority();
      rf_if.flags_load = 1; rf_if.flags_wdata = 4'b1010;
      rf_if.psr_load = 1; rf_if.psr_w_sel = 0; rf_if.psr_wdata = 32'h13;
      tick(); idle(); #1;
      vecs++; if (rf_if.psr_rdata !== 32'h13) begin errs++; $display("FAIL prio_psr_over_flags got %h exp 13", rf_if.psr_rdata); end
      rf_if.flags_load = 1; rf_if.flags_wdata = 4'b1010;
      tick(); idle(); #1;
      vecs++; if (rf_if.psr_rdata !== 32'hA0000013) begin errs++; $display("FAIL flags_only got %h exp A0000013", rf_if.psr_rdata); end
      rf_if.psr_load = 1; rf_if.psr_w_sel = 1; rf_if.psr_wdata = 32'hABCD;
      tick(); idle();
      rf_if.psr_r_sel = 1; #1;
      vecs++; if (rf_if.psr_rdata !== 32'hABCD) begin errs++; $display("FAIL spsr_write got %h exp ABCD", rf_if.psr_rdata); end
      do_cpsr(32'h10);
      rf_if.psr_load = 1; rf_if.psr_w_sel = 1; rf_if.psr_wdata = 32'h1234;
      tick(); idle();
      rf_if.psr_r_sel = 1; #1;
      vecs++; if (rf_if.psr_rdata !== 0) begin errs++; $display("FAIL spsr_usr got %h exp 0", rf_if.psr_rdata); end
      rf_if.psr_r_sel = 0;
   endtask

   task automatic test_bypass();
      logic [DW-1:0] exp_now;
`ifdef RF_BYPASS_EN
      exp_now = 32'h1234;
`else
      exp_now = 32'h0;
`endif
      set_rd(2, 4'd5);
      rf_if.wr_en = 1; rf_if.wr_addr = 4'd5; rf_if.wr_data = 32'h1234;
      #1;
      vecs++; if (rd(2) !== exp_now) begin errs++; $display("FAIL bypass_same_cycle got %h exp %h", rd(2), exp_now); end
      tick(); idle(); #1;
      vecs++; if (rd(2) !== 32'h1234) begin errs++; $display("FAIL bypass_next_cycle got %h exp 1234", rd(2)); end
   endtask

   initial begin
      test_reset();
      test_banking();
      test_collision();
      test_exception();
      test_priority();
      test_bypass();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
